// File: rtl/uart_tx_feeder.sv
// Character FIFO that paces a downstream UART sender: one frame per FIFO entry, with guard gaps.
// Optional sticky drop flag with clear input when UART_TX_FEEDER_OVERFLOW_EN is defined.
module uart_tx_feeder #(
   parameter int DATA_SIZE    = 7,
   parameter int CLK_FREQ_HZ  = 50_000_000,
   parameter int BAUD_RATE    = 960000,
   parameter int FIFO_DEPTH   = 8,
   parameter int GUARD_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [DATA_SIZE-1:0]          wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          tx_start,
   output logic [DATA_SIZE-1:0]          tx_data,
   output logic                          busy
`ifdef UART_TX_FEEDER_OVERFLOW_EN
   ,
   output logic                          overflow,
   input  logic                          clr_ovf
`endif
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int FRAME_CYCLES = CLKS_PER_BIT * (DATA_SIZE + 2) + GUARD_CYCLES;
   localparam int PW           = $clog2(FIFO_DEPTH);
   localparam int CW           = PW + 1;
   localparam int FW           = $clog2(FRAME_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t               state_reg, state_next;
   logic [FW-1:0]        frame_cnt_reg, frame_cnt_next;
   logic                 tx_start_reg, tx_start_next;
   logic [DATA_SIZE-1:0] tx_data_reg;
   logic                 busy_reg;
   logic [CW-1:0]        count_reg, count_next;
   logic                 empty_reg, full_reg;
   logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic                 pop, wr_accept;

   logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

   // A full FIFO still takes a write when the head leaves on the same edge.
   always_comb begin
      pop       = (state_reg == IDLE) && !empty_reg;
      wr_accept = wr_en && (!full_reg || pop);
      count_next = count_reg;
      case ({wr_accept, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      frame_cnt_next = frame_cnt_reg;
      tx_start_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pop) begin
               state_next     = START;
               frame_cnt_next = '0;
               tx_start_next  = 1'b1;
            end
         end
         START: begin
            frame_cnt_next = frame_cnt_reg + FW'(1);
            if (frame_cnt_reg == FW'(CLKS_PER_BIT - 1)) begin
               state_next    = WAIT;
               tx_start_next = 1'b0;
            end else begin
               tx_start_next = 1'b1;
            end
         end
         WAIT: begin
            frame_cnt_next = frame_cnt_reg + FW'(1);
            if (frame_cnt_reg == FW'(FRAME_CYCLES - 1)) begin
               state_next     = IDLE;
               frame_cnt_next = '0;
            end
         end
         default: begin
            state_next     = IDLE;
            frame_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         frame_cnt_reg <= '0;
         tx_start_reg  <= 1'b0;
         tx_data_reg   <= '0;
         busy_reg      <= 1'b0;
         count_reg     <= '0;
         empty_reg     <= 1'b1;
         full_reg      <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         frame_cnt_reg <= frame_cnt_next;
         tx_start_reg  <= tx_start_next;
         busy_reg      <= (state_next != IDLE);
         count_reg     <= count_next;
         empty_reg     <= (count_next == '0);
         full_reg      <= (count_next == CW'(FIFO_DEPTH));
         if (wr_accept)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + PW'(1);
            tx_data_reg <= mem[rd_ptr_reg];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept)
         mem[wr_ptr_reg] <= wr_data;
   end

`ifdef UART_TX_FEEDER_OVERFLOW_EN
   logic overflow_reg;
   logic drop;

   assign drop = wr_en && full_reg && !pop;

   // Setting wins over clearing so a drop on the clearing edge is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow_reg <= 1'b0;
      else if (drop)
         overflow_reg <= 1'b1;
      else if (clr_ovf)
         overflow_reg <= 1'b0;
   end

   assign overflow = overflow_reg;
`endif

   assign full     = full_reg;
   assign empty    = empty_reg;
   assign count    = count_reg;
   assign tx_start = tx_start_reg;
   assign tx_data  = tx_data_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scenario bench for uart_tx_feeder: scoreboard of expected characters popped at each tx_start rise.
module tb_uart_tx_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [6:0] wr_data = '0;
   logic       full, empty, tx_start, busy;
   logic [3:0] count;
   logic [6:0] tx_data;
`ifdef UART_TX_FEEDER_OVERFLOW_EN
   logic       overflow;
   logic       clr_ovf = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rises = 0;
   logic prev_start = 1'b0;
   logic [6:0] exp_q[$];
   int rise_t[$];
   logic rise_e[$];

   always #5 clk = ~clk;

   uart_tx_feeder dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count),
      .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
`ifdef UART_TX_FEEDER_OVERFLOW_EN
      , .overflow(overflow), .clr_ovf(clr_ovf)
`endif
   );

   // Advance one clock and score any tx_start rise against the expected queue.
   task automatic step();
      logic [6:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (tx_start && !prev_start) begin
         rises++;
         rise_t.push_back(cyc);
         rise_e.push_back(empty);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx_start: tx_data=%h, none expected", tx_data);
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               errors++;
               $display("FAIL frame_data: tx_data=%h expected %h", tx_data, e);
            end else
               $display("frame tx_data=%h at cycle %0d", tx_data, cyc);
         end
      end
      prev_start = tx_start;
   endtask

   task automatic wr(input logic [6:0] d);
      wr_en = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(busy === 1'b0 && empty === 1'b1 && exp_q.size() == 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: busy=%b empty=%b pending=%0d", busy, empty, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({tx_start, busy, full, empty} !== 4'b0001 || count !== 4'd0 || tx_data !== 7'd0) begin
         errors++;
         $display("FAIL reset_state: start=%b busy=%b full=%b empty=%b count=%0d data=%h expected 0,0,0,1,0,00",
                  tx_start, busy, full, empty, count, tx_data);
      end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_overflow: overflow=%b expected 0", overflow);
      end
`endif
      @(negedge clk) reset = 1'b1;
      prev_start = 1'b0;
   endtask

   task automatic test_single();
      int hi, bz, n;
      exp_q.push_back(7'h57);
      wr(7'b1010111);
      checks++;
      if (count !== 4'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin
         errors++;
         $display("FAIL single_enqueue: count=%0d empty=%b start=%b expected 1,0,0", count, empty, tx_start);
      end
      step();
      checks++;
      if (tx_start !== 1'b1 || busy !== 1'b1 || tx_data !== 7'h57 || count !== 4'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL single_pop: start=%b busy=%b data=%h count=%0d empty=%b expected 1,1,57,0,1",
                  tx_start, busy, tx_data, count, empty);
      end
      hi = 1; bz = 1; n = 0;
      while (busy === 1'b1 && n < 1000) begin
         step();
         n++;
         if (tx_start === 1'b1) hi++;
         if (busy === 1'b1) bz++;
      end
      checks++;
      if (hi != 52) begin
         errors++;
         $display("FAIL start_width: tx_start high %0d cycles expected 52", hi);
      end
      checks++;
      if (bz != 472) begin
         errors++;
         $display("FAIL busy_width: busy high %0d cycles expected 472", bz);
      end
      checks++;
      if (tx_data !== 7'h57) begin
         errors++;
         $display("FAIL data_hold: tx_data=%h expected 57", tx_data);
      end
   endtask

   task automatic test_back_to_back();
      rise_t.delete();
      rise_e.delete();
      exp_q.push_back(7'h11); exp_q.push_back(7'h22); exp_q.push_back(7'h33);
      wr(7'h11); wr(7'h22); wr(7'h33);
      wait_idle(3000);
      checks++;
      if (rise_t.size() != 3) begin
         errors++;
         $display("FAIL b2b_rises: %0d rises expected 3", rise_t.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (rise_t[i] - rise_t[i-1] != 473) begin
               errors++;
               $display("FAIL b2b_spacing: gap %0d expected 473", rise_t[i] - rise_t[i-1]);
            end
         end
         checks++;
         if (rise_e[0] !== 1'b0 || rise_e[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty: empty at 1st/3rd pop %b/%b expected 0/1", rise_e[0], rise_e[2]);
         end
      end
   endtask

   task automatic test_overflow();
      int n;
      exp_q.push_back(7'h40);
      wr(7'h40);
      step();
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_q.push_back(7'(8'h41 + i));
         wr(7'(8'h41 + i));
         checks++;
         if (count !== 4'((i < 8) ? i + 1 : 8) || full !== (i >= 7)) begin
            errors++;
            $display("FAIL fill_%0d: count=%0d full=%b expected %0d,%b", i, count, full,
                     (i < 8) ? i + 1 : 8, (i >= 7));
         end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
         checks++;
         if (overflow !== (i >= 8)) begin
            errors++;
            $display("FAIL overflow_%0d: overflow=%b expected %b", i, overflow, (i >= 8));
         end
`endif
      end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: overflow=%b expected 0", overflow);
      end
`endif
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         step();
         n++;
      end
      exp_q.push_back(7'h4B);
      wr(7'h4B);
      checks++;
      if (count !== 4'd8 || full !== 1'b1 || tx_start !== 1'b1) begin
         errors++;
         $display("FAIL write_on_pop: count=%0d full=%b start=%b expected 8,1,1", count, full, tx_start);
      end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL write_on_pop_ovf: overflow=%b expected 0", overflow);
      end
`endif
      wait_idle(6000);
   endtask

   task automatic test_reset_mid();
      int r0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(7'(8'h61 + i));
         wr(7'(8'h61 + i));
      end
      repeat (40) step();
      checks++;
      if (tx_start !== 1'b1 || count !== 4'd3) begin
         errors++;
         $display("FAIL pre_reset: start=%b count=%0d expected 1,3", tx_start, count);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({tx_start, busy, full, empty} !== 4'b0001 || count !== 4'd0 || tx_data !== 7'd0) begin
         errors++;
         $display("FAIL reset_mid: start=%b busy=%b full=%b empty=%b count=%0d data=%h expected 0,0,0,1,0,00",
                  tx_start, busy, full, empty, count, tx_data);
      end
      exp_q.delete();
      prev_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      r0 = rises;
      repeat (600) step();
      checks++;
      if (rises != r0) begin
         errors++;
         $display("FAIL post_reset_quiet: %0d rises expected 0", rises - r0);
      end
   endtask

   task automatic test_first_write();
      @(negedge clk) reset = 1'b0;
      prev_start = 1'b0;
      #1;
      wr_en = 1'b1;
      wr_data = 7'h5A;
      exp_q.push_back(7'h5A);
      @(negedge clk) reset = 1'b1;
      step();
      wr_en = 1'b0;
      checks++;
      if (count !== 4'd1 || empty !== 1'b0) begin
         errors++;
         $display("FAIL first_write: count=%0d empty=%b expected 1,0", count, empty);
      end
      wait_idle(1000);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_first_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
